// File: rtl/odu_chk_data.sv
// odu_chk_data: per-channel receive checker for the ODU test-data stream.
// Tracks each channel's sequence counter and fill pattern. It produces sticky
// per-channel error flags, per-channel lock status, a saturating total error
// count, and a sticky flag for words that carry an out-of-range channel id.
module odu_chk_data #(
   parameter int NUM_CH     = 80,
   parameter int DATA_WIDTH = 395,
   parameter int CHID_WIDTH = 7,
   parameter int SEQ_WIDTH  = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     enable_chid,
   input  logic [NUM_CH-1:0]     type_chid,
   input  logic                  clr_err,
   input  logic                  data_valid,
   input  logic [CHID_WIDTH-1:0] chid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [NUM_CH-1:0]     error_chid,
   output logic [NUM_CH-1:0]     lock_chid,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic                  bad_chid
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } ch_state_t;

   localparam logic [CHID_WIDTH:0]  NUM_CH_LIM = (CHID_WIDTH+1)'(NUM_CH);
   localparam logic [SEQ_WIDTH-1:0] SEQ_ONE    = SEQ_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

   // S1 registers
   logic                  v1;
   logic [CHID_WIDTH-1:0] chid1;
   logic [DATA_WIDTH-1:0] data1;

   // S2 registers
   logic                  v2;
   logic                  bad2;
   logic [CHID_WIDTH-1:0] chid2;
   logic [SEQ_WIDTH-1:0]  seq2;
   logic                  fill_ok2;

   // S2 combinational terms
   logic                  in_range1;
   logic                  type_sel1;
   logic                  fill_ok1;

   // Per-channel state and expected sequence
   ch_state_t             state_q [NUM_CH];
   ch_state_t             state_d [NUM_CH];
   logic [SEQ_WIDTH-1:0]  exp_q   [NUM_CH];
   logic [SEQ_WIDTH-1:0]  exp_d   [NUM_CH];
   logic                  err_d;

   // S3 registers feeding the output update
   logic                  err3;
   logic                  bad3;
   logic [CHID_WIDTH-1:0] chid3;

   // Output next-values
   logic [NUM_CH-1:0]     err_vec;
   logic [NUM_CH-1:0]     lock_vec;
   logic [CNT_WIDTH-1:0]  cnt_base;
   logic [CNT_WIDTH-1:0]  cnt_next;

   // S1: valid bit, cleared on reset so in-flight words are dropped
   always_ff @(posedge clk) begin
      if (!rst) v1 <= 1'b0;
      else      v1 <= data_valid;
   end

   // S1: word capture, no reset needed
   always_ff @(posedge clk) begin
      chid1 <= chid_in;
      data1 <= data_in;
   end

   // S2: range check and fill check against the channel's current fill type
   always_comb begin
      in_range1 = ({1'b0, chid1} < NUM_CH_LIM);
      type_sel1 = 1'b0;
      if (in_range1) type_sel1 = type_chid[chid1];
      fill_ok1  = type_sel1 ? (&data1[DATA_WIDTH-1:SEQ_WIDTH])
                            : ~(|data1[DATA_WIDTH-1:SEQ_WIDTH]);
   end

   // S2: control bits, cleared on reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         v2   <= 1'b0;
         bad2 <= 1'b0;
      end else begin
         v2   <= v1 & in_range1;
         bad2 <= v1 & ~in_range1;
      end
   end

   // S2: datapath capture
   always_ff @(posedge clk) begin
      chid2    <= chid1;
      seq2     <= data1[SEQ_WIDTH-1:0];
      fill_ok2 <= fill_ok1;
   end

   // S3: per-channel next state. State is read and written in the same stage,
   // so a back-to-back word on the same channel always sees the previous
   // word's update without a separate bypass path.
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      err_d   = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!enable_chid[i]) state_d[i] = UNLOCKED;
      end
      if (v2 && enable_chid[chid2]) begin
         case (state_q[chid2])
            UNLOCKED: begin
               if (!fill_ok2) begin
                  err_d = 1'b1;
               end else begin
                  state_d[chid2] = LOCKED;
                  exp_d[chid2]   = seq2 + SEQ_ONE;
               end
            end
            LOCKED: begin
               if ((seq2 != exp_q[chid2]) || !fill_ok2) err_d = 1'b1;
               exp_d[chid2] = seq2 + SEQ_ONE;
            end
            default: ;
         endcase
      end
   end

   // S3: channel state register and event capture
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= UNLOCKED;
         err3 <= 1'b0;
         bad3 <= 1'b0;
      end else begin
         state_q <= state_d;
         err3    <= err_d;
         bad3    <= bad2;
      end
   end

   // S3: expected sequence storage and event channel, no reset needed
   always_ff @(posedge clk) begin
      exp_q <= exp_d;
      chid3 <= chid2;
   end

   // Output next-values. A clear coinciding with a new error keeps the new
   // error: the flag stays set and the count restarts at one.
   always_comb begin
      err_vec = '0;
      if (err3) err_vec[chid3] = 1'b1;
      lock_vec = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) lock_vec[i] = (state_q[i] == LOCKED);
      cnt_base = clr_err ? '0 : err_cnt;
      cnt_next = cnt_base;
      if (err3 && (cnt_base != '1)) cnt_next = cnt_base + CNT_ONE;
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         error_chid <= '0;
         lock_chid  <= '0;
         err_cnt    <= '0;
         bad_chid   <= 1'b0;
      end else begin
         error_chid <= (clr_err ? '0 : error_chid) | err_vec;
         lock_chid  <= lock_vec;
         err_cnt    <= cnt_next;
         bad_chid   <= (bad_chid & ~clr_err) | bad3;
      end
   end

endmodule

// File: tb/tb_odu_chk_data.sv
// tb_odu_chk_data: directed self-checking bench for odu_chk_data.
module tb_odu_chk_data;

   localparam int NUM_CH     = 80;
   localparam int DATA_WIDTH = 395;
   localparam int CHID_WIDTH = 7;
   localparam int SEQ_WIDTH  = 32;
   localparam int CNT_WIDTH  = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_CH-1:0]     enable_chid;
   logic [NUM_CH-1:0]     type_chid;
   logic                  clr_err;
   logic                  data_valid;
   logic [CHID_WIDTH-1:0] chid_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic [NUM_CH-1:0]     error_chid;
   logic [NUM_CH-1:0]     lock_chid;
   logic [CNT_WIDTH-1:0]  err_cnt;
   logic                  bad_chid;

   int checks = 0;
   int fails  = 0;

   odu_chk_data #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .CHID_WIDTH(CHID_WIDTH),
      .SEQ_WIDTH(SEQ_WIDTH), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .enable_chid(enable_chid), .type_chid(type_chid),
      .clr_err(clr_err), .data_valid(data_valid), .chid_in(chid_in),
      .data_in(data_in), .error_chid(error_chid), .lock_chid(lock_chid),
      .err_cnt(err_cnt), .bad_chid(bad_chid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   typedef struct {
      logic [6:0]  ch;
      logic [31:0] seq;
      logic        ones;
      int          flip;
      logic        lock_before;
      logic        lock_after;
      logic        err_after;
      logic [15:0] cnt_after;
   } vec_t;

   vec_t tbl [11];
   logic [NUM_CH-1:0] exp_err;
   logic [NUM_CH-1:0] exp_lock;
   logic [15:0]       prev_cnt;
   logic [31:0]       s;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_WIDTH-1:0] make_word(input logic [31:0] seq, input logic ones, input int flip);
      logic [DATA_WIDTH-1:0] w;
      w = ones ? '1 : '0;
      w[SEQ_WIDTH-1:0] = seq;
      if (flip >= 0) w[SEQ_WIDTH+flip] = ~w[SEQ_WIDTH+flip];
      return w;
   endfunction

   task automatic drive(input logic [6:0] ch, input logic [31:0] seq, input logic ones, input int flip);
      chid_in    = ch;
      data_in    = make_word(seq, ones, flip);
      data_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic settle();
      data_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{7'd5,  32'd100,        1'b0, -1,  1'b0, 1'b1, 1'b0, 16'd0};
      tbl[1]  = '{7'd5,  32'd101,        1'b0, -1,  1'b1, 1'b1, 1'b0, 16'd0};
      tbl[2]  = '{7'd5,  32'd102,        1'b0, -1,  1'b1, 1'b1, 1'b0, 16'd0};
      tbl[3]  = '{7'd5,  32'd103,        1'b0, -1,  1'b1, 1'b1, 1'b0, 16'd0};
      tbl[4]  = '{7'd5,  32'd110,        1'b0, -1,  1'b1, 1'b1, 1'b1, 16'd1};
      tbl[5]  = '{7'd5,  32'd111,        1'b0, -1,  1'b1, 1'b1, 1'b0, 16'd1};
      tbl[6]  = '{7'd79, 32'hFFFFFFFE,   1'b1, -1,  1'b0, 1'b1, 1'b0, 16'd1};
      tbl[7]  = '{7'd79, 32'hFFFFFFFF,   1'b1, -1,  1'b1, 1'b1, 1'b0, 16'd1};
      tbl[8]  = '{7'd79, 32'd0,          1'b1, -1,  1'b1, 1'b1, 1'b0, 16'd1};
      tbl[9]  = '{7'd79, 32'd1,          1'b1, -1,  1'b1, 1'b1, 1'b0, 16'd1};
      tbl[10] = '{7'd79, 32'd2,          1'b1, 200, 1'b1, 1'b1, 1'b1, 16'd2};

      rst         = 1'b0;
      clr_err     = 1'b0;
      data_valid  = 1'b0;
      chid_in     = '0;
      data_in     = '0;
      enable_chid = '0;
      type_chid   = '0;
      enable_chid[0]  = 1'b1;
      enable_chid[1]  = 1'b1;
      enable_chid[3]  = 1'b1;
      enable_chid[5]  = 1'b1;
      enable_chid[79] = 1'b1;
      type_chid[79]   = 1'b1;
      exp_err  = '0;
      exp_lock = '0;

      repeat (3) @(negedge clk);
      check("reset_error_chid", error_chid, '0);
      check("reset_lock_chid",  lock_chid,  '0);
      check("reset_err_cnt",    err_cnt,    '0);
      check("reset_bad_chid",   bad_chid,   '0);
      rst = 1'b1;
      @(negedge clk);

      // Table: single words, latency checked one edge early, then results
      prev_cnt = 16'd0;
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].ch, tbl[i].seq, tbl[i].ones, tbl[i].flip);
         data_valid = 1'b0;
         repeat (2) @(negedge clk);
         check("early_lock", lock_chid[tbl[i].ch], tbl[i].lock_before);
         check("early_cnt",  err_cnt, prev_cnt);
         @(negedge clk);
         exp_lock[tbl[i].ch] = tbl[i].lock_after;
         exp_err[tbl[i].ch]  = exp_err[tbl[i].ch] | tbl[i].err_after;
         check("vec_lock_chid",  lock_chid,  exp_lock);
         check("vec_error_chid", error_chid, exp_err);
         check("vec_err_cnt",    err_cnt,    tbl[i].cnt_after);
         prev_cnt = tbl[i].cnt_after;
      end

      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      exp_err = '0;
      check("clr1_error_chid", error_chid, '0);
      check("clr1_err_cnt",    err_cnt,    '0);
      check("clr1_lock_chid",  lock_chid,  exp_lock);

      // Interleaved ch0/ch1 every cycle, ch1 skips 55, then ch0 back-to-back
      for (int i = 0; i < 10; i++) begin
         drive(7'd0, 32'(i), 1'b0, -1);
         if (i < 9) begin
            s = (i < 5) ? 32'(50 + i) : 32'(51 + i);
            drive(7'd1, s, 1'b0, -1);
         end
      end
      drive(7'd0, 32'd10, 1'b0, -1);
      drive(7'd0, 32'd11, 1'b0, -1);
      drive(7'd0, 32'd12, 1'b0, -1);
      settle();
      exp_err[1]  = 1'b1;
      exp_lock[0] = 1'b1;
      exp_lock[1] = 1'b1;
      check("ilv_error_chid", error_chid, exp_err);
      check("ilv_err_cnt",    err_cnt,    16'd1);
      check("ilv_lock_chid",  lock_chid,  exp_lock);

      // Out-of-range channel ids
      drive(7'd80,  32'd0, 1'b0, -1);
      drive(7'd127, 32'd5, 1'b1, -1);
      settle();
      check("bad_bad_chid",   bad_chid,   1'b1);
      check("bad_err_cnt",    err_cnt,    16'd1);
      check("bad_error_chid", error_chid, exp_err);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      exp_err = '0;
      check("clr2_bad_chid",   bad_chid,   1'b0);
      check("clr2_error_chid", error_chid, '0);
      check("clr2_err_cnt",    err_cnt,    '0);
      check("clr2_lock_chid",  lock_chid,  exp_lock);

      // Lock ch3, put an error on ch5, then clear coincident with a ch3 error
      drive(7'd3, 32'd7, 1'b0, -1);
      settle();
      exp_lock[3] = 1'b1;
      check("ch3_lock_chid", lock_chid, exp_lock);
      drive(7'd5, 32'd200, 1'b0, -1);
      settle();
      exp_err[5] = 1'b1;
      check("ch5_err_cnt",    err_cnt,    16'd1);
      check("ch5_error_chid", error_chid, exp_err);
      drive(7'd3, 32'd20, 1'b0, -1);
      data_valid = 1'b0;
      repeat (2) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      exp_err    = '0;
      exp_err[3] = 1'b1;
      check("coinc_error_chid", error_chid, exp_err);
      check("coinc_err_cnt",    err_cnt,    16'd1);

      // Disable ch3
      enable_chid[3] = 1'b0;
      repeat (2) @(negedge clk);
      exp_lock[3] = 1'b0;
      check("dis_lock_chid", lock_chid, exp_lock);

      // Reset mid-stream with a word in flight
      drive(7'd0, 32'd99, 1'b0, -1);
      data_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("rst_error_chid", error_chid, '0);
      check("rst_lock_chid",  lock_chid,  '0);
      check("rst_err_cnt",    err_cnt,    '0);
      check("rst_bad_chid",   bad_chid,   1'b0);
      repeat (4) @(negedge clk);
      check("post_rst_error_chid", error_chid, '0);
      check("post_rst_lock_chid",  lock_chid,  '0);
      check("post_rst_err_cnt",    err_cnt,    '0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
